// File: rtl/tpu_host_sequencer.sv
// tpu_host_sequencer: Avalon-MM master that runs one TPU matrix-multiply job end to end.
// Loads weights and inputs from src, issues the control writes, polls status after each
// phase and streams result words to dst through a one-entry holding register.
// Optional feature: define TPU_HOST_TIMEOUT_EN to bound each polling phase at POLL_LIMIT
// status reads; without it polling is unbounded and error is tied low.
module tpu_host_sequencer #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_LIMIT   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  weight_base,
    input  logic [7:0]  input_base,
    input  logic [7:0]  output_base,
    input  logic [8:0]  num_weight,
    input  logic [8:0]  num_input,
    input  logic [8:0]  num_output,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [63:0] src_data,
    output logic        dst_valid,
    input  logic        dst_ready,
    output logic [63:0] dst_data,
    output logic [9:0]  master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [63:0] master_writedata,
    output logic [7:0]  master_byteenable,
    input  logic [63:0] master_readdata,
    input  logic        master_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        StIdle, StLoadW, StLoadI, StCtrlRst, StFill, StPollFill, StDrain,
        StPollDrain, StMul, StPollMul, StReadOut, StFin
    } state_e;

    localparam logic [7:0] LatInit = 8'(READ_LATENCY);

    state_e      state_q, state_d, poll_next;
    logic [7:0]  wbase_q, wbase_d, ibase_q, ibase_d, obase_q, obase_d;
    logic [8:0]  nw_q, nw_d, ni_q, ni_d, no_q, no_d;
    logic [8:0]  idx_q, idx_d;
    logic        rd_pend_q, rd_pend_d;
    logic [7:0]  lat_q, lat_d;
    logic [63:0] hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        rsp, poll_hit, rd_req, wr_req, src_rdy;
    logic [9:0]  addr;
    logic [63:0] wdata;
`ifdef TPU_HOST_TIMEOUT_EN
    logic        err_q, err_d;
    logic [31:0] poll_cnt_q, poll_cnt_d;
`endif

    // Next-state logic: job sequencing, bus requests and read-response tracking.
    always_comb begin
        state_d    = state_q;
        wbase_d    = wbase_q;
        ibase_d    = ibase_q;
        obase_d    = obase_q;
        nw_d       = nw_q;
        ni_d       = ni_q;
        no_d       = no_q;
        idx_d      = idx_q;
        rd_pend_d  = rd_pend_q;
        lat_d      = lat_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
`ifdef TPU_HOST_TIMEOUT_EN
        err_d      = err_q;
        poll_cnt_d = poll_cnt_q;
`endif
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        src_rdy = 1'b0;
        addr    = '0;
        wdata   = '0;

        // Response data is valid READ_LATENCY cycles after the read was accepted.
        rsp = rd_pend_q && (lat_q == 8'd1);
        if (rd_pend_q) begin
            lat_d = lat_q - 8'd1;
            if (rsp) rd_pend_d = 1'b0;
        end

        poll_hit  = master_readdata[2];
        poll_next = StReadOut;
        if (state_q == StPollFill) begin
            poll_hit  = master_readdata[0];
            poll_next = StDrain;
        end else if (state_q == StPollDrain) begin
            poll_hit  = master_readdata[1];
            poll_next = StMul;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    wbase_d = weight_base;
                    ibase_d = input_base;
                    obase_d = output_base;
                    nw_d    = num_weight;
                    ni_d    = num_input;
                    no_d    = num_output;
                    idx_d   = '0;
                    state_d = StLoadW;
`ifdef TPU_HOST_TIMEOUT_EN
                    err_d      = 1'b0;
                    poll_cnt_d = '0;
`endif
                end
            end
            StLoadW, StLoadI: begin
                if ((state_q == StLoadW ? nw_q : ni_q) == 9'd0) begin
                    state_d = (state_q == StLoadW) ? StLoadI : StCtrlRst;
                end else begin
                    src_rdy = !master_waitrequest;
                    wr_req  = src_valid;
                    wdata   = src_data;
                    addr    = (state_q == StLoadW) ? {2'b10, wbase_q + idx_q[7:0]}
                                                   : {2'b01, ibase_q + idx_q[7:0]};
                    if (src_valid && !master_waitrequest) begin
                        if (idx_q == (state_q == StLoadW ? nw_q : ni_q) - 9'd1) begin
                            idx_d   = '0;
                            state_d = (state_q == StLoadW) ? StLoadI : StCtrlRst;
                        end else begin
                            idx_d = idx_q + 9'd1;
                        end
                    end
                end
            end
            StCtrlRst, StFill, StDrain, StMul: begin
                wr_req = 1'b1;
                if (state_q == StCtrlRst)   wdata = 64'hF;
                else if (state_q == StFill) wdata = {44'd0, wbase_q, 4'h1};
                else if (state_q == StDrain) wdata = 64'h2;
                else                        wdata = {44'd0, obase_q, ibase_q, 4'h3};
                if (!master_waitrequest) begin
                    if (state_q == StCtrlRst)   state_d = StFill;
                    else if (state_q == StFill) state_d = StPollFill;
                    else if (state_q == StDrain) state_d = StPollDrain;
                    else                        state_d = StPollMul;
                end
            end
            StPollFill, StPollDrain, StPollMul: begin
                if (!rd_pend_q) begin
                    rd_req = 1'b1;
                    if (!master_waitrequest) begin
                        rd_pend_d = 1'b1;
                        lat_d     = LatInit;
`ifdef TPU_HOST_TIMEOUT_EN
                        poll_cnt_d = poll_cnt_q + 32'd1;
`endif
                    end
                end else if (rsp) begin
                    if (poll_hit) begin
                        state_d = poll_next;
`ifdef TPU_HOST_TIMEOUT_EN
                        poll_cnt_d = '0;
`endif
                    end
`ifdef TPU_HOST_TIMEOUT_EN
                    else if (poll_cnt_q >= POLL_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end
`endif
                end
            end
            StReadOut: begin
                if (no_q == 9'd0) begin
                    state_d = StFin;
                end else begin
                    // Only read when the holding register is free and nothing is in flight.
                    if (!rd_pend_q && !hold_vld_q && idx_q != no_q) begin
                        rd_req = 1'b1;
                        addr   = {2'b11, obase_q + idx_q[7:0]};
                        if (!master_waitrequest) begin
                            rd_pend_d = 1'b1;
                            lat_d     = LatInit;
                            idx_d     = idx_q + 9'd1;
                        end
                    end
                    if (rsp) begin
                        hold_d     = master_readdata;
                        hold_vld_d = 1'b1;
                    end
                    if (hold_vld_q && dst_ready) begin
                        hold_vld_d = 1'b0;
                        if (idx_q == no_q) state_d = StFin;
                    end
                end
            end
            StFin: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wbase_q    <= '0;
            ibase_q    <= '0;
            obase_q    <= '0;
            nw_q       <= '0;
            ni_q       <= '0;
            no_q       <= '0;
            idx_q      <= '0;
            rd_pend_q  <= 1'b0;
            lat_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
`ifdef TPU_HOST_TIMEOUT_EN
            err_q      <= 1'b0;
            poll_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wbase_q    <= wbase_d;
            ibase_q    <= ibase_d;
            obase_q    <= obase_d;
            nw_q       <= nw_d;
            ni_q       <= ni_d;
            no_q       <= no_d;
            idx_q      <= idx_d;
            rd_pend_q  <= rd_pend_d;
            lat_q      <= lat_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
`ifdef TPU_HOST_TIMEOUT_EN
            err_q      <= err_d;
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    // Outputs; reset kills bus requests at once, overriding the waitrequest hold.
    always_comb begin
        master_read       = rd_req && !reset;
        master_write      = wr_req && !reset;
        src_ready         = src_rdy && !reset;
        master_address    = addr;
        master_writedata  = wdata;
        master_byteenable = (master_read || master_write) ? 8'hFF : 8'h00;
        dst_valid         = hold_vld_q;
        dst_data          = hold_q;
        busy              = (state_q != StIdle) && (state_q != StFin);
        done              = (state_q == StFin);
`ifdef TPU_HOST_TIMEOUT_EN
        error             = err_q;
`else
        error             = 1'b0;
`endif
    end

endmodule

// File: doc/tpu_host_sequencer.md
# tpu_host_sequencer

Avalon-MM master that drives the TPU matrix-multiplier slave through one complete job. A job loads weights and inputs from a source stream, issues the RESET, FILL_FIFO, DRAIN_FIFO and MULTIPLY control writes, polls the status word after each phase, and reads result words out to a sink stream. It sits between a host-side data mover and the TPU's bus connector, so that software only starts a job and collects results.

## Interface
- `READ_LATENCY`, default 1: cycles from an accepted read to valid `master_readdata`.
- `POLL_LIMIT`, default 4096: maximum status reads per polling phase. Used only with the timeout feature.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle job launch. Ignored while `busy`=1.
- `weight_base`, `input_base`, `output_base` in 8 each: TPU memory base indices. Sampled on `start`.
- `num_weight`, `num_input`, `num_output` in 9 each: 64-bit word counts, range 0..256. A count of 0 skips that transfer. Sampled on `start`.
- `src_valid` in 1, `src_ready` out 1, `src_data` in 64: write-data stream. All weight words come first, then all input words.
- `dst_valid` out 1, `dst_ready` in 1, `dst_data` out 64: result stream.
- `master_address` out 10: bits [9:8] region (00 control, 01 input, 10 weight, 11 output), bits [7:0] word index.
- `master_read` out 1, `master_write` out 1.
- `master_writedata` out 64, `master_byteenable` out 8: byteenable is always 8'hFF while read or write is asserted, 0 otherwise.
- `master_readdata` in 64, `master_waitrequest` in 1.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse at job end.
- `error` out 1: timeout flag. Holds until the next `start`.

## Operation
- States: IDLE → LOAD_W → LOAD_I → CTRL_RST → FILL → POLL_FILL → DRAIN → POLL_DRAIN → MUL → POLL_MUL → READ_OUT → FIN → IDLE.
- LOAD_W:
  - `src_ready` = ¬`master_waitrequest`.
  - A beat transfers when `src_valid` && `src_ready`. The write goes to {2'b10, weight_base+k}, where k counts 0..num_weight-1.
  - Index arithmetic is 8-bit and wraps modulo 256.
- LOAD_I: identical to LOAD_W, using region 01 and `input_base`.
- Control writes go to address 10'h000 with the following `master_writedata`:
  - CTRL_RST: 64'hF.
  - FILL: {44'd0, weight_base, 4'h1}.
  - DRAIN: 64'h2.
  - MUL: {44'd0, output_base, input_base, 4'h3}.
- POLL states:
  - Read address 10'h000 and capture `master_readdata` READ_LATENCY cycles after acceptance.
  - Advance when the relevant bit is set: bit0 for POLL_FILL, bit1 for POLL_DRAIN, bit2 for POLL_MUL.
  - Otherwise reissue the read on the next cycle.
  - Only one read is outstanding at any time.
- READ_OUT:
  - Read {2'b11, output_base+j}, where j counts 0..num_output-1.
  - Captured data goes to a one-entry holding register driving `dst_data`/`dst_valid`.
  - The next read is issued only after the held word is accepted (`dst_valid` && `dst_ready`).
- Any Avalon request (read or write) holds address, data and read/write stable while `master_waitrequest`=1.
- A phase whose count is 0 passes to the next state in one cycle with no bus activity.
- FIN: `done`=1 for one cycle, `busy` drops in the same cycle, then the block returns to IDLE.
- `start` arriving in the same cycle as FIN is ignored.

## Timing
- Reset values: all outputs 0, `master_byteenable`=0, holding register empty, state IDLE.
- A synchronous `reset` mid-job aborts at the next edge. Bus signals deassert immediately, even while `master_waitrequest` is high (reset overrides the hold rule).
- Throughput:
  - Load phases: one word per cycle with `src_valid`=1 and `master_waitrequest`=0.
  - Read-out: one word per READ_LATENCY+2 cycles with `dst_ready`=1.
- Minimum gap from `start` to the first bus request: 1 cycle.
- Each control write occupies exactly one accepted cycle. The following POLL read begins on the next cycle.

## Configuration
- `TPU_HOST_TIMEOUT_EN` defined:
  - Each POLL state counts status reads issued.
  - Reaching POLL_LIMIT without the bit set sets `error`=1, skips the remaining phases and enters FIN (`done` still pulses).
- `TPU_HOST_TIMEOUT_EN` undefined: polling is unbounded, and `error` is tied to 0.

## Test plan
- Job with weight_base=0, input_base=0, output_base=0, counts 16/16/16, status bits set on first poll → 16 writes to 0x200-0x20F, 16 writes to 0x100-0x10F, control writes F,1,2,3, 16 reads 0x300-0x30F; `dst` words match the model; one `done`.
- weight_base=8'hF8, num_weight=16 → write addresses wrap 0x2F8..0x2FF, then 0x200..0x207.
- `master_waitrequest` held high for 3 cycles on the FILL write → address 0x000 and writedata 0x001 stable for all 4 cycles; exactly one FILL accepted.
- `dst_ready` low for 10 cycles during READ_OUT → `dst_data` held; no new read issued; no word lost or duplicated.
- With `TPU_HOST_TIMEOUT_EN`, POLL_LIMIT=4, bit1 never set → exactly 4 status reads in POLL_DRAIN; `error`=1; `done` pulses; no MULTIPLY write is issued.
- `reset` asserted mid LOAD_I, then a new `start` → `busy`=0 after one edge; the new job replays from LOAD_W.
